// File: rtl/dram_word_arbiter.sv
// Two-requester word arbiter over a 1-bit-wide distributed RAM, moving one bit per cycle.
// Define DRAM_ARB_VERIFY_EN to read back every written word and flag mismatches on err.
module dram_word_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 16,
    localparam int BW = $clog2(WORD_WIDTH),
    localparam int WA = ADDR_WIDTH - BW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [WA-1:0]         waddr0,
    input  logic [WA-1:0]         waddr1,
    input  logic [WORD_WIDTH-1:0] wdata0,
    input  logic [WORD_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [WORD_WIDTH-1:0] rdata0,
    output logic [WORD_WIDTH-1:0] rdata1,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_d,
    output logic                  ram_we,
    input  logic                  ram_o
);

`ifdef DRAM_ARB_VERIFY_EN
    typedef enum logic [1:0] {IDLE, XFER, VERIFY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
`endif

    localparam logic [BW-1:0] CNT_LAST = BW'(WORD_WIDTH - 1);

    state_t                state;
    logic [BW-1:0]         cnt;
    logic [BW-1:0]         cnt_nx;
    logic                  gnt;
    logic                  last_gnt;
    logic                  l_we;
    logic [WA-1:0]         l_addr;
    logic [WORD_WIDTH-1:0] l_data;
    logic [WORD_WIDTH-1:0] cap;
    logic [WORD_WIDTH-1:0] word_rd;
    logic                  pick1;
`ifdef DRAM_ARB_VERIFY_EN
    logic                  mism;
    logic                  bit_bad;
`endif

    // last_gnt = 1 means requester 1 was served last, so requester 0 wins a tie.
    assign pick1  = req1 & (~req0 | ~last_gnt);
    assign cnt_nx = cnt + 1'b1;

    always_comb begin
        word_rd      = cap;
        word_rd[cnt] = ram_o;
    end

`ifdef DRAM_ARB_VERIFY_EN
    assign bit_bad = ram_o ^ l_data[cnt];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            l_we     <= 1'b0;
            l_addr   <= '0;
            l_data   <= '0;
            cap      <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            err      <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            ram_a    <= '0;
            ram_d    <= 1'b0;
            ram_we   <= 1'b0;
`ifdef DRAM_ARB_VERIFY_EN
            mism     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt      <= pick1;
                        last_gnt <= pick1;
                        l_we     <= pick1 ? we1 : we0;
                        l_addr   <= pick1 ? waddr1 : waddr0;
                        l_data   <= pick1 ? wdata1 : wdata0;
                        cnt      <= '0;
                        ram_a    <= {(pick1 ? waddr1 : waddr0), {BW{1'b0}}};
                        ram_we   <= pick1 ? we1 : we0;
                        ram_d    <= pick1 ? (we1 & wdata1[0]) : (we0 & wdata0[0]);
                        state    <= XFER;
                    end
                end
                XFER: begin
                    cap <= word_rd;
                    if (cnt == CNT_LAST) begin
                        ram_we <= 1'b0;
                        ram_d  <= 1'b0;
`ifdef DRAM_ARB_VERIFY_EN
                        if (l_we) begin
                            cnt   <= '0;
                            mism  <= 1'b0;
                            ram_a <= {l_addr, {BW{1'b0}}};
                            state <= VERIFY;
                        end else begin
`else
                        begin
`endif
                            ram_a <= '0;
                            ack0  <= ~gnt;
                            ack1  <= gnt;
                            err   <= 1'b0;
                            if (!l_we) begin
                                if (gnt) rdata1 <= word_rd;
                                else     rdata0 <= word_rd;
                            end
                            state <= DONE;
                        end
                    end else begin
                        cnt   <= cnt_nx;
                        ram_a <= {l_addr, cnt_nx};
                        ram_d <= l_we & l_data[cnt_nx];
                    end
                end
`ifdef DRAM_ARB_VERIFY_EN
                VERIFY: begin
                    mism <= mism | bit_bad;
                    if (cnt == CNT_LAST) begin
                        ram_a <= '0;
                        ack0  <= ~gnt;
                        ack1  <= gnt;
                        err   <= mism | bit_bad;
                        state <= DONE;
                    end else begin
                        cnt   <= cnt_nx;
                        ram_a <= {l_addr, cnt_nx};
                    end
                end
`endif
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_word_arbiter.sv
// Bench for dram_word_arbiter: bit-level RAM model, word-level reference model,
// directed pins of latency/arbitration/reset behaviour, then randomized traffic.
module tb_dram_word_arbiter;
    localparam int AW = 8;
    localparam int WW = 16;
    localparam int WA = 4;
`ifdef DRAM_ARB_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int LAT_W = VERIFY ? 33 : 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [WA-1:0] waddr0 = '0, waddr1 = '0;
    logic [WW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, err, ram_d, ram_we, ram_o;
    logic [WW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_a;

    dram_word_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .err(err),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_o(ram_o)
    );

    always #5 clk = ~clk;

    // 256x1 RAM: asynchronous read, synchronous write, optional stuck-at-0 cell.
    logic       ram_mem [0:255];
    bit         stuck_en = 1'b0;
    logic [7:0] stuck_addr = 8'h35;
    assign ram_o = (stuck_en && ram_a == stuck_addr) ? 1'b0 : ram_mem[ram_a];
    always @(posedge clk) if (ram_we) ram_mem[ram_a] <= ram_d;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction occupies a fixed number of cycles after its grant.
    bit            m_valid = 1'b0, m_busy = 1'b0, m_g = 1'b0, m_we = 1'b0, m_lastg = 1'b1;
    int            m_k = 0, m_len = 0;
    logic [WA-1:0] m_addr = '0;
    logic [WW-1:0] m_data = '0;
    logic [WW-1:0] m_rd [2];
    logic [WW-1:0] m_mem [16];

    always @(negedge clk) begin
        logic [AW-1:0] e_a;
        logic          e_we, e_d, e_err, chk_d, done_now;
        logic [1:0]    e_ack;
        int            nb;
        done_now = 1'b0;
        if (m_valid) begin
            e_a = '0; e_we = 1'b0; e_d = 1'b0; e_ack = 2'b00; e_err = 1'b0; chk_d = 1'b1;
            if (m_busy) begin
                m_k++;
                if (m_k >= 1 && m_k <= WW) begin
                    e_a   = {m_addr, 4'(m_k - 1)};
                    e_we  = m_we;
                    e_d   = m_we & m_data[m_k - 1];
                    chk_d = m_we;
                end else if (VERIFY && m_we && m_k > WW && m_k <= 2 * WW) begin
                    e_a   = {m_addr, 4'(m_k - WW - 1)};
                    chk_d = 1'b0;
                end
                if (m_k == m_len) begin
                    e_ack[m_g] = 1'b1;
                    if (m_we) begin
                        m_mem[m_addr] = m_data;
                        e_err = VERIFY && stuck_en && m_addr == stuck_addr[7:4]
                                && m_data[stuck_addr[3:0]];
                    end else begin
                        m_rd[m_g] = m_mem[m_addr];
                    end
                    done_now = 1'b1;
                end
            end
            chk("ram_a", ram_a, e_a);
            chk("ram_we", ram_we, e_we);
            if (chk_d) chk("ram_d", ram_d, e_d);
            chk("ack", {ack1, ack0}, e_ack);
            chk("err", err, e_err);
            chk("rdata0", rdata0, m_rd[0]);
            chk("rdata1", rdata1, m_rd[1]);
            if (done_now) m_busy = 1'b0;
        end
        if (rst) begin
            if (m_valid && m_busy && m_we) begin
                nb = (m_k < WW) ? m_k : WW;
                for (int j = 0; j < nb; j++) m_mem[m_addr][j] = m_data[j];
            end
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_lastg = 1'b1;
            m_rd[0] = '0;
            m_rd[1] = '0;
        end else if (m_valid && !m_busy && !done_now && (req0 || req1)) begin
            m_g     = (req0 && req1) ? !m_lastg : req1;
            m_lastg = m_g;
            m_we    = m_g ? we1 : we0;
            m_addr  = m_g ? waddr1 : waddr0;
            m_data  = m_g ? wdata1 : wdata0;
            m_len   = m_we ? LAT_W : 17;
            m_k     = 0;
            m_busy  = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_params(input int r);
        if (r == 0) begin
            we0 = 1'($urandom_range(0, 1)); waddr0 = 4'($urandom); wdata0 = 16'($urandom);
        end else begin
            we1 = 1'($urandom_range(0, 1)); waddr1 = 4'($urandom); wdata1 = 16'($urandom);
        end
    endtask

    initial begin
        logic [15:0] seq;
        int cyc, e;
        for (int i = 0; i < 256; i++) ram_mem[i] = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_rd[0] = '0;
        m_rd[1] = '0;

        // Write 0xA5C3 to word 3, read it back through requester 1.
        repeat (3) step();
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b1; waddr0 = 4'd3; wdata0 = 16'hA5C3;
        seq = 16'hA5C3;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("d1_ram_a", ram_a, 8'h30 + 8'(k - 1));
            chk("d1_ram_d", ram_d, seq[k - 1]);
            chk("d1_ram_we", ram_we, 1'b1);
        end
        step();
        chk("d1_ack", {ack1, ack0}, 2'b01);
        req0 = 1'b0;
        step();
        req1 = 1'b1; we1 = 1'b0; waddr1 = 4'd3;
        repeat (16) step();
        chk("d2_ack_early", {ack1, ack0}, 2'b00);
        step();
        chk("d2_ack", {ack1, ack0}, 2'b10);
        chk("d2_rdata1", rdata1, 16'hA5C3);
        chk("d2_rdata0", rdata0, 16'h0000);
        req1 = 1'b0;
        step();

        // Simultaneous writes after reset, both held: grants alternate 0,1,0,1.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b1; waddr0 = 4'd1; wdata0 = 16'h1111;
        req1 = 1'b1; we1 = 1'b1; waddr1 = 4'd2; wdata1 = 16'h2222;
        cyc = 0;
        for (int n = 1; n <= 4; n++) begin
            e = n * LAT_W + (n - 1);
            while (cyc < e) begin step(); cyc++; end
            chk("rr_ack", {ack1, ack0}, (n % 2 == 1) ? 2'b01 : 2'b10);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Reset at counter 7 of a write: low byte lands, nothing is acknowledged.
        req0 = 1'b1; we0 = 1'b1; waddr0 = 4'd7; wdata0 = 16'h1234;
        repeat (8) step();
        chk("rs_ram_a", ram_a, 8'h77);
        rst = 1'b1; req0 = 1'b0;
        step();
        chk("rs_ram_we", ram_we, 1'b0);
        chk("rs_ram_a0", ram_a, 8'h00);
        chk("rs_ram_d", ram_d, 1'b0);
        chk("rs_ack", {ack1, ack0}, 2'b00);
        chk("rs_err", err, 1'b0);
        chk("rs_rdata", {rdata1, rdata0}, 32'h0);
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; waddr0 = 4'd7;
        repeat (17) step();
        chk("rs_rd_ack", {ack1, ack0}, 2'b01);
        chk("rs_rd_data", rdata0, 16'h0034);
        req0 = 1'b0;
        step();

`ifdef DRAM_ARB_VERIFY_EN
        stuck_en = 1'b1;
        req0 = 1'b1; we0 = 1'b1; waddr0 = 4'd3; wdata0 = 16'hFFFF;
        repeat (33) step();
        chk("vf_ack_bad", {ack1, ack0}, 2'b01);
        chk("vf_err_bad", err, 1'b1);
        req0 = 1'b0;
        step();
        req0 = 1'b1; waddr0 = 4'd2;
        repeat (33) step();
        chk("vf_ack_ok", {ack1, ack0}, 2'b01);
        chk("vf_err_ok", err, 1'b0);
        req0 = 1'b0;
        step();
        stuck_en = 1'b0;
`endif

        // Random traffic with occasional reset pulses.
        for (int c = 0; c < 4000; c++) begin
            step();
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (ack0) begin
                    if ($urandom_range(0, 1) == 1) new_params(0); else req0 = 1'b0;
                end else if (!req0 && $urandom_range(0, 2) == 0) begin
                    req0 = 1'b1; new_params(0);
                end
                if (ack1) begin
                    if ($urandom_range(0, 1) == 1) new_params(1); else req1 = 1'b0;
                end else if (!req1 && $urandom_range(0, 2) == 0) begin
                    req1 = 1'b1; new_params(1);
                end
            end
        end
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dram_word_arbiter.md
DRAM_WORD_ARBITER -- requirements
Module: dram_word_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning RAM bit-address width (256x1 single-port distributed RAM).
REQ-002 SHALL have parameter WORD_WIDTH, default 16, meaning bits per word; power of two; WA = ADDR_WIDTH - log2(WORD_WIDTH), default 4.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  requester n transfer request.
REQ-006 SHALL have ports we0/we1  input  1  1 = write word, 0 = read word.
REQ-007 SHALL have ports waddr0/waddr1  input  WA  word address.
REQ-008 SHALL have ports wdata0/wdata1  input  WORD_WIDTH  write data.
REQ-009 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports rdata0/rdata1  output  WORD_WIDTH  read result, valid with ack, held until that requester's next read completes.
REQ-011 SHALL have port err  output  1  verify-mismatch flag, valid with ack.
REQ-012 SHALL have ports ram_a  output  ADDR_WIDTH, ram_d  output  1, ram_we  output  1, ram_o  input  1 (RAM asynchronous read, synchronous write on clk).

Function
REQ-013 SHALL implement FSM states IDLE, XFER, (VERIFY), DONE; reset state IDLE.
REQ-014 SHALL sample req0/req1 only in IDLE; on any asserted request, grant one, latch its we/waddr/wdata, clear bit counter, enter XFER next cycle.
REQ-015 SHALL arbitrate round-robin: both requesting -> grant requester not granted last; pointer after reset favours requester 0.
REQ-016 In XFER, SHALL drive ram_a = {latched waddr, bit counter}, counter 0..WORD_WIDTH-1, one bit per cycle, LSB first.
REQ-017 For write, SHALL drive ram_we = 1 and ram_d = wdata[counter] each XFER cycle; ram_we = 0 in every other state.
REQ-018 For read, SHALL capture ram_o into bit [counter] of a shift/capture register each XFER cycle.
REQ-019 After counter reaches WORD_WIDTH-1, SHALL go to DONE (or VERIFY, REQ-027); DONE asserts ack of granted requester for exactly one cycle, updates its rdata on reads, then returns to IDLE.
REQ-020 Latency: request seen in IDLE at cycle 0 -> XFER cycles 1..16 -> ack at cycle 17 (WORD_WIDTH=16).
REQ-021 Requester SHALL hold req and inputs until ack; req deassertion after grant SHALL NOT abort the transfer; req held after ack is a new request at the next IDLE.
REQ-022 Ungranted requester's ack SHALL stay 0; at most one ack high per cycle.
REQ-023 ram_a SHALL be 0 and ram_d 0 outside XFER/VERIFY.

Reset
REQ-024 On rst: state IDLE, counter 0, ack0/ack1 0, err 0, rdata0/rdata1 0, ram_we 0, ram_a 0, ram_d 0, arbitration pointer to requester 0.
REQ-025 Reset mid-transfer SHALL abort: ram_we 0 from the first cycle after the reset edge, no ack issued; partially written bits remain in RAM.
REQ-026 Reset SHALL override a simultaneous request; requests are first considered the cycle after rst deasserts.

Configuration
REQ-027 With DRAM_ARB_VERIFY_EN defined: after a write XFER, SHALL enter VERIFY, re-walk the same WORD_WIDTH addresses with ram_we = 0, compare ram_o to latched wdata; err = 1 with ack if any bit differs; write ack at cycle 33; reads unaffected.
REQ-028 Without DRAM_ARB_VERIFY_EN: no VERIFY state; err tied 0; write ack at cycle 17.

Verification
REQ-029 After reset, req0 write waddr0=3, wdata0=16'hA5C3 -> ram_a 8'h30..8'h3F on cycles 1..16, ram_d = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, ack0 at cycle 17.
REQ-030 Then req1 read waddr1=3 -> ack1 at cycle 17 of that transfer, rdata1 = 16'hA5C3, rdata0 unchanged.
REQ-031 req0 and req1 (both writes) asserted together at cycle 0 after reset -> ack0 at cycle 17, ack1 at cycle 35; repeat with both held -> requester 0 and 1 alternate.
REQ-032 rst pulsed at XFER counter 7 of a write -> ram_we 0 next cycle, no ack, all outputs at reset values; subsequent request proceeds normally.
REQ-033 With DRAM_ARB_VERIFY_EN, RAM model stuck-at-0 on address 8'h35, write 16'hFFFF to word 3 -> ack0 at cycle 33 with err = 1; write to word 2 -> err = 0.
